// File: rtl/fifo_arbiter.sv
// Round-robin arbiter sharing one FIFO between two writers and one reader.
// Keeps a shadow occupancy count and flags any disagreement with the FIFO.
module fifo_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] din1,
  input  logic                  rd_req,
  input  logic [CNT_W-1:0]      data_count,
  input  logic                  wr_err,
  input  logic                  rd_err,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] din,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rd_gnt,
  output logic [CNT_W-1:0]      cnt,
  output logic                  sync_err
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWr0  = 2'd1;
  localparam logic [1:0] StWr1  = 2'd2;
  localparam logic [1:0] StRd   = 2'd3;

  localparam logic [1:0] OwnW0 = 2'd0;
  localparam logic [1:0] OwnW1 = 2'd1;
  localparam logic [1:0] OwnRd = 2'd2;

  localparam logic [CNT_W-1:0] CntFull = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic [1:0]            state_q, state_d;
  logic [1:0]            last_q, last_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  sync_err_q, sync_err_d;

  logic [2:0] elig;
  logic       win_vld;
  logic [1:0] winner;

  assign elig[0] = req0 && (cnt_q < CntFull);
  assign elig[1] = req1 && (cnt_q < CntFull);
  assign elig[2] = rd_req && (cnt_q != '0);

  // Search starts just after the previous winner, cyclic W0 -> W1 -> RD.
  always_comb begin
    win_vld = |elig;
    winner  = OwnW0;
    unique case (last_q)
      OwnW0: begin
        if (elig[1])      winner = OwnW1;
        else if (elig[2]) winner = OwnRd;
        else              winner = OwnW0;
      end
      OwnW1: begin
        if (elig[2])      winner = OwnRd;
        else if (elig[0]) winner = OwnW0;
        else              winner = OwnW1;
      end
      default: begin
        if (elig[0])      winner = OwnW0;
        else if (elig[1]) winner = OwnW1;
        else              winner = OwnRd;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    unique case (state_q)
      StIdle: begin
        if (win_vld) begin
          last_d = winner;
          unique case (winner)
            OwnW0: begin
              state_d = StWr0;
              cnt_d   = cnt_q + CntOne;
              din_d   = din0;
            end
            OwnW1: begin
              state_d = StWr1;
              cnt_d   = cnt_q + CntOne;
              din_d   = din1;
            end
            default: begin
              state_d = StRd;
              cnt_d   = cnt_q - CntOne;
            end
          endcase
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // The FIFO count only settles in IDLE, one cycle after the enable it reflects.
  always_comb begin
    sync_err_d = sync_err_q | wr_err | rd_err |
                 ((state_q == StIdle) && (data_count != cnt_q));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      last_q     <= OwnRd;
      cnt_q      <= '0;
      din_q      <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      din_q      <= din_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign wr_en    = (state_q == StWr0) || (state_q == StWr1);
  assign rd_en    = (state_q == StRd);
  assign gnt0     = (state_q == StWr0);
  assign gnt1     = (state_q == StWr1);
  assign rd_gnt   = (state_q == StRd);
  assign din      = din_q;
  assign cnt      = cnt_q;
  assign sync_err = sync_err_q;

endmodule

// File: doc/fifo_arbiter.md
Name: fifo_arbiter

Overview:
Arbitrates one 8-deep FIFO between two write requesters (W0, W1) and one read requester (RD). The FIFO accepts one operation per cycle, so the arbiter grants at most one operation per issue cycle, using round-robin. It keeps a shadow occupancy count so it never issues a write when full or a read when empty. It sits directly in front of the FIFO's wr_en/rd_en/din inputs and checks the FIFO's data_count and error flags against its own view.

Parameters:
DATA_WIDTH, 32, width of din0/din1/din
DEPTH, 8, FIFO capacity in words
CNT_W, 4, width of occupancy counters; must hold 0..DEPTH

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
req0  input  1  W0 write request; level, held until gnt0
din0  input  DATA_WIDTH  W0 write data; stable while req0=1
req1  input  1  W1 write request
din1  input  DATA_WIDTH  W1 write data
rd_req  input  1  read request
data_count  input  CNT_W  FIFO occupancy reported by the FIFO
wr_err  input  1  FIFO write-error status
rd_err  input  1  FIFO read-error status
wr_en  output  1  FIFO write enable, registered
rd_en  output  1  FIFO read enable, registered
din  output  DATA_WIDTH  FIFO write data, registered
gnt0  output  1  one-cycle grant to W0, coincident with wr_en
gnt1  output  1  one-cycle grant to W1, coincident with wr_en
rd_gnt  output  1  one-cycle grant to RD, coincident with rd_en
cnt  output  CNT_W  shadow occupancy, 0..DEPTH
sync_err  output  1  sticky fault flag

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous, active-low. Assertion immediately forces every output low, din=0, cnt=0, state=IDLE and last=RD, so after reset the priority order is W0, W1, RD. An operation in flight is dropped and cnt is not updated.
- States: IDLE, WR0, WR1, RD. All outputs are registered from state and cnt.
- IDLE: at each rising edge, form the eligible set:
  - W0 if req0 && cnt<DEPTH
  - W1 if req1 && cnt<DEPTH
  - RD if rd_req && cnt>0
- Round-robin: search starts at the requester after last, in cyclic order W0→W1→RD→W0. The first eligible requester wins, last takes the winner, and the state moves to WR0, WR1 or RD. If nothing is eligible, stay in IDLE.
- WR0/WR1: for exactly one cycle wr_en=1, the matching gnt=1, and din = the winner's data sampled at the granting edge. cnt increments on the granting edge.
- RD: for exactly one cycle rd_en=1 and rd_gnt=1. cnt decrements on the granting edge.
- WR0/WR1/RD always return to IDLE on the next edge. Peak throughput is one operation every 2 cycles.
- Handshake: a requester sees gnt for one cycle and must drop req, or present new data for a further transfer, before the next edge. The arbiter samples requests only in IDLE, so it never double-grants a requester.
- wr_en and rd_en are never high together.
- Full (cnt=DEPTH): writes are never granted and their req stays pending. Empty (cnt=0): reads are never granted.
- Simultaneous requests resolve by round-robin only; no requester has fixed priority. Any continuously eligible requester is granted within 3 grants (≤6 cycles).
- Consistency check: sync_err is set, and held until reset, if any of these is seen at a rising edge:
  - state==IDLE && data_count!=cnt
  - wr_err=1
  - rd_err=1
- sync_err does not block arbitration.
- Width rule: cnt never exceeds DEPTH and never goes below 0. The eligibility rules guarantee this; there is no wrap-around.

Test Plan:
1. Reset with req0=1: all outputs 0. After reset_n rises, the first edge grants W0: cycle 1 has wr_en=1, gnt0=1, din=din0=32'hA5A5_0001; cnt reads 1 in the following cycle.
2. Hold req0, req1 and rd_req high, cnt=1: grant sequence W0, W1, RD, W0, …, with one IDLE cycle between grants. wr_en and rd_en are never both high.
3. Fill: req0 held, 8 grants bring cnt to 8. req0 then stays pending with no gnt0 for ≥10 cycles. Asserting rd_req gives rd_gnt, cnt=7, then gnt0 resumes.
4. Empty: rd_req held from reset: no rd_gnt while cnt=0. A single req1 write → gnt1, then rd_gnt on the next IDLE decision; cnt back to 0.
5. Drive data_count=3 while cnt=2 in IDLE, or pulse wr_err for one cycle: sync_err rises on the next edge, stays high, and arbitration continues. Reset clears sync_err.
6. Drop reset_n during a WR1 cycle: wr_en and gnt1 fall immediately without waiting for a clock edge, cnt=0, and the next grant after release is W0 if req0 is high.
